// File: rtl/frame_write_engine.sv
// Frame RAM write engine: turns NIOS custom-instruction commands into
// single-bit writes on the 64x64 VGA frame RAM write port.
module frame_write_engine #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned WORD_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           dataa,
  input  logic [31:0]           datab,
  output logic                  done,
  output logic [31:0]           result,
  output logic                  busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [1:0] OP_WORD  = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_PIXEL = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                 state;
  logic [WORD_BITS-1:0]   shift;
  logic                   fill_mode;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       total;

  logic [1:0]             opcode;
  logic [ADDR_WIDTH-1:0]  base;
  logic                   unused_dataa;

  assign opcode       = dataa[31:30];
  assign base         = dataa[ADDR_WIDTH-1:0];
  assign unused_dataa = ^dataa[29:ADDR_WIDTH];

  // Command FSM: the first write is issued on the accept edge so that
  // writes occupy cycles 1..N and done lands on cycle N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      fill_mode <= 1'b0;
      count     <= '0;
      total     <= '0;
      done      <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          result <= '0;
          wr_en  <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            count <= CNT_W'(1);
            case (opcode)
              OP_WORD: begin
                state     <= WRITE;
                wr_en     <= 1'b1;
                wr_addr   <= base;
                wr_data   <= datab[0];
                shift     <= datab[WORD_BITS-1:0] >> 1;
                fill_mode <= 1'b0;
                total     <= CNT_W'(WORD_BITS);
              end
              OP_FILL: begin
                state     <= WRITE;
                wr_en     <= 1'b1;
                wr_addr   <= '0;
                wr_data   <= datab[0];
                fill_mode <= 1'b1;
                total     <= CNT_W'(DEPTH);
              end
              OP_PIXEL: begin
                state     <= WRITE;
                wr_en     <= 1'b1;
                wr_addr   <= base;
                wr_data   <= datab[0];
                fill_mode <= 1'b0;
                total     <= CNT_W'(1);
              end
              default: begin
                state  <= DONE;
                done   <= 1'b1;
                result <= 32'h8000_0000;
              end
            endcase
          end
        end

        WRITE: begin
          if (count == total) begin
            state  <= DONE;
            wr_en  <= 1'b0;
            done   <= 1'b1;
            result <= 32'(count);
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_WIDTH'(1);
            // FILL holds the latched pixel bit; other commands shift LSB first
            if (!fill_mode) begin
              wr_data <= shift[0];
            end
            shift <= shift >> 1;
            count <= count + CNT_W'(1);
          end
        end

        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          result <= '0;
          busy   <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
